// File: rtl/brq_dmem_arbiter.sv
// brq_dmem_arbiter: round-robin arbiter serialising NumPorts requesters onto one data memory
// Ports: brq_clk/brq_rst clock and async active-low reset; req_* per-port request bundle with
// req_ready_o accept strobe; rsp_valid_o/rsp_rdata_o completion pulse and shared read data;
// mem_* single memory port driven one transaction at a time; busy_o while a transaction is in flight.
module brq_dmem_arbiter #(
  parameter int NumPorts = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15,
  parameter int MemLatency = 1
) (
  input  logic                           brq_clk,
  input  logic                           brq_rst,
  input  logic [NumPorts-1:0]            req_valid_i,
  output logic [NumPorts-1:0]            req_ready_o,
  input  logic [NumPorts-1:0]            req_we_i,
  input  logic [3*NumPorts-1:0]          req_byte_en_i,
  input  logic [AddrWidth*NumPorts-1:0]  req_addr_i,
  input  logic [DataWidth*NumPorts-1:0]  req_wdata_i,
  output logic [NumPorts-1:0]            rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  output logic                           mem_read_en_o,
  output logic                           mem_write_en_o,
  output logic [2:0]                     mem_byte_en_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic                           busy_o
);
  localparam int IdxW = $clog2(NumPorts);
  localparam int CntW = MemLatency > 1 ? $clog2(MemLatency) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [IdxW-1:0] ptr, idx, grant_idx, p;
  logic grant_any, we;
  logic [CntW-1:0] cnt;
  // Scan from the highest offset down so the port closest after ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    p = '0;
    for (int i = NumPorts-1; i >= 0; i--) begin
      p = IdxW'((int'(ptr) + i) % NumPorts);
      if (req_valid_i[p]) begin
        grant_any = 1'b1;
        grant_idx = p;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = grant_any ? ISSUE : IDLE;
    else if (state == ISSUE) state_nxt = WAIT;
    else if (state == WAIT) state_nxt = cnt == '0 ? RESP : WAIT;
    else state_nxt = IDLE;
  end
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      we <= 1'b0;
      cnt <= '0;
      mem_byte_en_o <= '0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      rsp_rdata_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        idx <= grant_idx;
        ptr <= grant_idx == IdxW'(NumPorts-1) ? '0 : grant_idx + 1'b1;
        we <= req_we_i[grant_idx];
        mem_byte_en_o <= req_byte_en_i[3*grant_idx +: 3];
        mem_addr_o <= req_addr_i[AddrWidth*grant_idx +: AddrWidth];
        mem_wdata_o <= req_wdata_i[DataWidth*grant_idx +: DataWidth];
      end
      if (state == ISSUE) cnt <= CntW'(MemLatency-1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0) rsp_rdata_o <= we ? '0 : mem_rdata_i;
    end
  end
  // Ready is combinational from req_valid_i, so it is masked while reset is held.
  assign req_ready_o = (brq_rst && state == IDLE && grant_any) ? NumPorts'(1) << grant_idx : '0;
  assign rsp_valid_o = state == RESP ? NumPorts'(1) << idx : '0;
  assign mem_read_en_o = state == ISSUE && !we;
  assign mem_write_en_o = state == ISSUE && we;
  assign busy_o = state != IDLE;
endmodule
